// File: rtl/ula_pkg.sv
// Shared types and constants for the digit-serial ULA and its combinational slice.
package ula_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_NOTA  = 3'b101,
        OP_PASSA = 3'b110,
        OP_RSVD  = 3'b111
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int SLICE_W_DEFAULT = 4;

endpackage

// File: rtl/ula_slice.sv
// Combinational SLICE_W-bit ALU slice; SUB inverts b here so the caller only supplies the carry.
module ula_slice
    import ula_pkg::*;
#(
    parameter int SLICE_W = SLICE_W_DEFAULT
) (
    input  op_t                op,
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] f,
    output logic               cout,
    output logic               c_msb
);

    logic [SLICE_W-1:0] b_eff;
    logic [SLICE_W:0]   sum;

    always_comb begin
        b_eff = (op == OP_SUB) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, cin};
        f     = '0;
        cout  = 1'b0;
        c_msb = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                f     = sum[SLICE_W-1:0];
                cout  = sum[SLICE_W];
                // Carry into the MSB recovered from the MSB sum bit and its two addends.
                c_msb = sum[SLICE_W-1] ^ a[SLICE_W-1] ^ b_eff[SLICE_W-1];
            end
            OP_AND:   f = a & b;
            OP_OR:    f = a | b;
            OP_XOR:   f = a ^ b;
            OP_NOTA:  f = ~a;
            OP_PASSA: f = a;
            default:  f = '0;
        endcase
    end

endmodule

// File: rtl/ula_serial_n.sv
// Digit-serial N-bit ULA: one SLICE_W-bit slice per clock, LSB first, registered carry
// between slices, start/busy/done handshake with result and flags held until the next done.
module ula_serial_n
    import ula_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SLICE_W = SLICE_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam int NSLICES = WIDTH / SLICE_W;
    localparam int CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NSLICES - 1);

    // Handshake: start is taken on any edge where busy=0 (including the done cycle);
    // start while busy=1 is dropped, and done pulses one cycle after the last slice edge.
    state_t             state, next_state;
    logic               accept, last;
    op_t                op_q;
    logic [WIDTH-1:0]   a_sr, b_sr, res_sr, next_res;
    logic               carry_q;
    logic [CNT_W-1:0]   k;
    logic [SLICE_W-1:0] slice_f;
    logic               slice_cout, slice_cmsb;

    ula_slice #(.SLICE_W(SLICE_W)) u_slice (
        .op    (op_q),
        .a     (a_sr[SLICE_W-1:0]),
        .b     (b_sr[SLICE_W-1:0]),
        .cin   (carry_q),
        .f     (slice_f),
        .cout  (slice_cout),
        .c_msb (slice_cmsb)
    );

    generate
        if (NSLICES == 1) begin : g_single
            assign next_res = slice_f;
        end else begin : g_multi
            assign next_res = {slice_f, res_sr[WIDTH-1:SLICE_W]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (k == LAST_K) begin
                    last       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_ADD;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry_q <= 1'b0;
            k       <= '0;
            done    <= 1'b0;
            f       <= '0;
            cout    <= 1'b0;
            zero    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                op_q    <= op_t'(op);
                a_sr    <= a;
                b_sr    <= b;
                carry_q <= (op == OP_ADD) ? cin : (op == OP_SUB);
                k       <= '0;
            end else if (state == RUN) begin
                a_sr    <= a_sr >> SLICE_W;
                b_sr    <= b_sr >> SLICE_W;
                res_sr  <= next_res;
                carry_q <= slice_cout;
                k       <= k + CNT_W'(1);
                if (last) begin
                    f    <= next_res;
                    cout <= slice_cout;
                    zero <= (next_res == '0);
                    ovf  <= ((op_q == OP_ADD) || (op_q == OP_SUB)) & (slice_cmsb ^ slice_cout);
                end
            end
        end
    end

endmodule

// File: tb/tb_ula_serial_n.sv
// Directed bench for ula_serial_n at WIDTH=16 and WIDTH=8 with hand-computed expectations.
module tb_ula_serial_n;
    import ula_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start16 = 1'b0;
    logic [2:0]  op16 = 3'b000;
    logic [15:0] a16 = '0, b16 = '0;
    logic        cin16 = 1'b0;
    logic        busy16, done16, cout16, zero16, ovf16;
    logic [15:0] f16;

    logic        start8 = 1'b0;
    logic [2:0]  op8 = 3'b000;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        cin8 = 1'b0;
    logic        busy8, done8, cout8, zero8, ovf8;
    logic [7:0]  f8;

    logic        sel8 = 1'b0;
    logic        obs_busy, obs_done, obs_cout, obs_zero, obs_ovf;
    logic [15:0] obs_f;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    ula_serial_n #(.WIDTH(16), .SLICE_W(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .f(f16), .cout(cout16), .zero(zero16), .ovf(ovf16)
    );

    ula_serial_n #(.WIDTH(8), .SLICE_W(4)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .f(f8), .cout(cout8), .zero(zero8), .ovf(ovf8)
    );

    always_comb begin
        obs_busy = sel8 ? busy8 : busy16;
        obs_done = sel8 ? done8 : done16;
        obs_cout = sel8 ? cout8 : cout16;
        obs_zero = sel8 ? zero8 : zero16;
        obs_ovf  = sel8 ? ovf8  : ovf16;
        obs_f    = sel8 ? {8'h00, f8} : f16;
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Called #1 after the accept edge; returns edges until done and busy cycles seen.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = obs_busy ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (obs_done) break;
            if (obs_busy) bcnt++;
        end
    endtask

    task automatic run_op(input bit w8, input logic [2:0] o, input logic [15:0] av,
                          input logic [15:0] bv, input logic c, input logic [15:0] ef,
                          input logic ec, input logic ez, input logic eo, input int elat,
                          input string tag);
        int lat, bcnt;
        logic [15:0] f_hold;
        sel8 = w8;
        @(negedge clk);
        if (w8) begin
            op8 = o; a8 = av[7:0]; b8 = bv[7:0]; cin8 = c; start8 = 1'b1;
        end else begin
            op16 = o; a16 = av; b16 = bv; cin16 = c; start16 = 1'b1;
        end
        @(posedge clk);
        #1;
        start8  = 1'b0;
        start16 = 1'b0;
        wait_done(lat, bcnt);
        check({tag, " latency"}, lat, elat);
        check({tag, " busy_cycles"}, bcnt, elat);
        check({tag, " f"}, obs_f, ef);
        check({tag, " cout"}, obs_cout, ec);
        check({tag, " zero"}, obs_zero, ez);
        check({tag, " ovf"}, obs_ovf, eo);
        f_hold = obs_f;
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, obs_done, 1'b0);
        check({tag, " f_held"}, obs_f, ef);
        check({tag, " f_stable"}, obs_f, f_hold);
    endtask

    initial begin
        int lat, bcnt, dcount;

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy16, 1'b0);
        check("reset done", done16, 1'b0);
        check("reset f", f16, 16'h0000);
        check("reset cout", cout16, 1'b0);
        check("reset zero", zero16, 1'b0);
        check("reset ovf", ovf16, 1'b0);
        check("reset f8", f8, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        run_op(0, OP_ADD,   16'h00FF, 16'h0001, 0, 16'h0100, 0, 0, 0, 4, "add_ff_1");
        run_op(0, OP_ADD,   16'hFFFF, 16'h0001, 0, 16'h0000, 1, 1, 0, 4, "add_ffff_1");
        run_op(0, OP_ADD,   16'h7FFF, 16'h0001, 0, 16'h8000, 0, 0, 1, 4, "add_7fff_1");
        run_op(0, OP_ADD,   16'h000F, 16'h000F, 1, 16'h001F, 0, 0, 0, 4, "add_f_f_cin");
        run_op(0, OP_SUB,   16'h0007, 16'h0005, 1, 16'h0002, 1, 0, 0, 4, "sub_7_5");
        run_op(0, OP_SUB,   16'h0005, 16'h0007, 0, 16'hFFFE, 0, 0, 0, 4, "sub_5_7");
        run_op(0, OP_SUB,   16'h8000, 16'h0001, 0, 16'h7FFF, 1, 0, 1, 4, "sub_8000_1");
        run_op(0, OP_XOR,   16'hF0F0, 16'hFF00, 1, 16'h0FF0, 0, 0, 0, 4, "xor");
        run_op(0, OP_AND,   16'hF0F0, 16'hFF00, 0, 16'hF000, 0, 0, 0, 4, "and");
        run_op(0, OP_OR,    16'hF0F0, 16'hFF00, 0, 16'hFFF0, 0, 0, 0, 4, "or");
        run_op(0, OP_NOTA,  16'hF0F0, 16'hFF00, 0, 16'h0F0F, 0, 0, 0, 4, "not_a");
        run_op(0, OP_PASSA, 16'hF0F0, 16'hFF00, 0, 16'hF0F0, 0, 0, 0, 4, "pass_a");
        run_op(0, OP_RSVD,  16'hF0F0, 16'hFF00, 1, 16'h0000, 0, 1, 0, 4, "reserved");

        // Mid-run start is ignored and operand changes after accept have no effect.
        sel8 = 1'b0;
        @(negedge clk);
        op16 = OP_ADD; a16 = 16'h0001; b16 = 16'h0002; cin16 = 1'b0; start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0; a16 = 16'hAAAA; b16 = 16'h5555;
        @(posedge clk);
        #1;
        start16 = 1'b1; op16 = OP_XOR; a16 = 16'h1000; b16 = 16'h1000;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        wait_done(lat, bcnt);
        check("ignore_start latency", lat, 2);
        check("ignore_start f", f16, 16'h0003);
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done16) dcount++;
        end
        check("ignore_start no_extra_done", dcount, 0);
        check("ignore_start f_kept", f16, 16'h0003);

        // start held through the done cycle: second op starts with no idle gap.
        @(negedge clk);
        op16 = OP_ADD; a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0; start16 = 1'b1;
        @(posedge clk);
        #1;
        op16 = OP_SUB; a16 = 16'h0010; b16 = 16'h0001;
        wait_done(lat, bcnt);
        check("b2b first latency", lat, 4);
        check("b2b first f", f16, 16'h2345);
        check("b2b done_cycle busy", busy16, 1'b0);
        @(posedge clk);
        #1;
        check("b2b second accepted busy", busy16, 1'b1);
        check("b2b second done_low", done16, 1'b0);
        start16 = 1'b0;
        wait_done(lat, bcnt);
        check("b2b second latency", lat, 4);
        check("b2b second f", f16, 16'h000F);
        check("b2b second cout", cout16, 1'b1);

        // Asynchronous reset mid-run aborts the operation.
        @(negedge clk);
        op16 = OP_ADD; a16 = 16'h0100; b16 = 16'h0200; start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort busy", busy16, 1'b0);
        check("abort done", done16, 1'b0);
        check("abort f", f16, 16'h0000);
        check("abort cout", cout16, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done16) dcount++;
        end
        check("abort no_done", dcount, 0);
        check("abort f_after", f16, 16'h0000);
        run_op(0, OP_ADD, 16'h0003, 16'h0004, 0, 16'h0007, 0, 0, 0, 4, "add_3_4");

        run_op(1, OP_ADD, 16'h000F, 16'h0001, 0, 16'h0010, 0, 0, 0, 2, "w8 add_f_1");
        run_op(1, OP_ADD, 16'h00FF, 16'h0001, 0, 16'h0000, 1, 1, 0, 2, "w8 add_ff_1");
        run_op(1, OP_ADD, 16'h007F, 16'h0001, 0, 16'h0080, 0, 0, 1, 2, "w8 add_7f_1");
        run_op(1, OP_ADD, 16'h000F, 16'h000F, 1, 16'h001F, 0, 0, 0, 2, "w8 add_f_f_cin");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
